// File: rtl/checksum_frame_sched_pkg.sv
// rtl/checksum_frame_sched_pkg.sv - shared widths, state encoding and beat-count helpers
package checksum_frame_sched_pkg;

    localparam int REQ_ID_W = 1;
    localparam int DATA_W   = 8;
    localparam int POLY_W   = 4;
    localparam int RES_W    = 12;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEPT = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ACCEPT = ST_ACCEPT,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT,
        S_DONE   = ST_DONE,
        S_DRAIN  = ST_DRAIN
    } state_t;

    function automatic logic [2:0] popcount4(input logic [POLY_W-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // The core still answers an all-zero polynomial with a single zero beat.
    function automatic logic [2:0] beats_for_poly(input logic [POLY_W-1:0] p);
        logic [2:0] pc;
        pc = popcount4(p);
        return (pc == 3'd0) ? 3'd1 : pc;
    endfunction

endpackage

// File: rtl/checksum_frame_sched_rr_arb2.sv
// rtl/checksum_frame_sched_rr_arb2.sv - two-way round-robin arbiter, pointer advances on frame done
module checksum_frame_sched_rr_arb2
    import checksum_frame_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic                update,
    input  logic [REQ_ID_W-1:0] owner,
    output logic [REQ_ID_W-1:0] grant_id
);

    logic [REQ_ID_W-1:0] ptr;

    // On a tie the pointer side wins; a lone requester always wins.
    always_comb begin
        grant_id = ptr;
        if (req[0] && !req[1]) begin
            grant_id = 1'b0;
        end else if (req[1] && !req[0]) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~owner;
        end
    end

endmodule

// File: rtl/checksum_frame_sched.sv
// rtl/checksum_frame_sched.sv - frame-level round-robin scheduler sharing one checksum core
module checksum_frame_sched
    import checksum_frame_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_vld,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req0_last,
    input  logic [POLY_W-1:0]   req0_poly,
    output logic                req0_rdy,
    input  logic                req1_vld,
    input  logic [DATA_W-1:0]   req1_data,
    input  logic                req1_last,
    input  logic [POLY_W-1:0]   req1_poly,
    output logic                req1_rdy,
    output logic                cs_in_data_vld,
    output logic [DATA_W-1:0]   cs_in_data,
    output logic [POLY_W-1:0]   cs_polynomial,
    input  logic [RES_W-1:0]    cs_out_data,
    input  logic                cs_out_data_vld,
    output logic                res_vld,
    output logic [RES_W-1:0]    res_data,
    output logic [REQ_ID_W-1:0] res_id,
    output logic                res_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t              state;
    logic [REQ_ID_W-1:0] owner;
    logic [REQ_ID_W-1:0] grant_id;
    logic                last_q;
    logic                err;
    logic [2:0]          cnt;
    logic [TW-1:0]       timer;
    logic [RES_W-1:0]    acc;

    logic                own_vld;
    logic                own_rdy;
    logic                own_last;
    logic [DATA_W-1:0]   own_data;
    logic                hs;

    always_comb begin
        own_vld  = owner ? req1_vld  : req0_vld;
        own_rdy  = owner ? req1_rdy  : req0_rdy;
        own_last = owner ? req1_last : req0_last;
        own_data = owner ? req1_data : req0_data;
        hs       = own_vld && own_rdy;
    end

    checksum_frame_sched_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({req1_vld, req0_vld}),
        .update   (state == S_DONE),
        .owner    (owner),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            owner          <= 1'b0;
            last_q         <= 1'b0;
            err            <= 1'b0;
            cnt            <= 3'd0;
            timer          <= '0;
            acc            <= '0;
            req0_rdy       <= 1'b0;
            req1_rdy       <= 1'b0;
            cs_in_data_vld <= 1'b0;
            cs_in_data     <= '0;
            cs_polynomial  <= '0;
            res_vld        <= 1'b0;
            res_data       <= '0;
            res_id         <= 1'b0;
            res_err        <= 1'b0;
        end else begin
            cs_in_data_vld <= 1'b0;
            res_vld        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_vld || req1_vld) begin
                        owner         <= grant_id;
                        cs_polynomial <= grant_id ? req1_poly : req0_poly;
                        acc           <= '0;
                        err           <= 1'b0;
                        req0_rdy      <= ~grant_id;
                        req1_rdy      <= grant_id;
                        state         <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (hs) begin
                        cs_in_data     <= own_data;
                        last_q         <= own_last;
                        req0_rdy       <= 1'b0;
                        req1_rdy       <= 1'b0;
                        cs_in_data_vld <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= beats_for_poly(cs_polynomial);
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cs_out_data_vld) begin
                        acc   <= acc ^ cs_out_data;
                        timer <= '0;
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            if (last_q) begin
                                res_vld  <= 1'b1;
                                res_data <= acc ^ cs_out_data;
                                res_id   <= owner;
                                res_err  <= err;
                                state    <= S_DONE;
                            end else begin
                                req0_rdy <= ~owner;
                                req1_rdy <= owner;
                                state    <= S_ACCEPT;
                            end
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err <= 1'b1;
                        if (last_q) begin
                            res_vld  <= 1'b1;
                            res_data <= acc;
                            res_id   <= owner;
                            res_err  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            // Keep the owner locked and swallow the rest of its frame.
                            req0_rdy <= ~owner;
                            req1_rdy <= owner;
                            state    <= S_DRAIN;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (hs && own_last) begin
                        req0_rdy <= 1'b0;
                        req1_rdy <= 1'b0;
                        res_vld  <= 1'b1;
                        res_data <= acc;
                        res_id   <= owner;
                        res_err  <= err;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
